// File: rtl/updown_counter_param_pkg.sv
// updown_pkg: mode encodings and sizing helper shared by the up/down counter blocks
package updown_pkg;
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((64'sd1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if: control inputs and count/strobe outputs of the up/down counter
interface updown_counter_param_if #(parameter int WIDTH = 8);
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             carry;
  logic             borrow;
  modport master (output mode, load, load_val, input count, tick, carry, borrow);
  modport slave  (input mode, load, load_val, output count, tick, carry, borrow);
endinterface

// File: rtl/updown_counter_param_tick.sv
// tick_gen: free-running divide-by-DIV prescaler producing a one-cycle enable strobe
module tick_gen
  import updown_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  output logic tick
);
  localparam int W = clog2(DIV) > 0 ? clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] div_cnt;
  // prescaler counts 0..DIV-1 and wraps, independent of any counter control
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) div_cnt <= '0;
    else div_cnt <= div_cnt == LAST ? '0 : div_cnt + 1'b1;
  // reset gating keeps tick low in reset even when DIV=1 makes the decode always true
  assign tick = CPU_RESETN && div_cnt == LAST;
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: prescaled up/down counter with load, clear and carry/borrow (UPDOWN_SATURATE_EN selects saturation)
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint CLK_HZ    = 100_000_000,
  parameter longint TICK_HZ   = 1,
  parameter longint MAX_COUNT = (64'sd1 << WIDTH) - 1
) (
  input logic CLK100MHZ,
  input logic CPU_RESETN,
  updown_counter_param_if.slave bus
);
  localparam longint DIV_L = TICK_HZ > 0 ? CLK_HZ / TICK_HZ : 0;
  localparam int DIV = int'(DIV_L);
`ifdef UPDOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  if (WIDTH < 1 || WIDTH > 32 || DIV_L < 1 || DIV_L > 64'sd2147483647 ||
      MAX_COUNT < 0 || MAX_COUNT > (64'sd1 << WIDTH) - 1) begin : g_bad_cfg
    $error("updown_counter_param: illegal WIDTH/DIV/MAX_COUNT configuration");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  logic [WIDTH-1:0] n_count;
  logic             n_carry;
  logic             n_borrow;
  logic             at_max;
  logic             at_zero;
  logic             up;
  logic             dn;
  tick_gen #(.DIV(DIV)) u_tick (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .tick      (bus.tick)
  );
  // load beats clear beats tick-qualified stepping; overrun wraps or saturates but always flags
  always_comb begin
    at_max   = bus.count == MAX;
    at_zero  = bus.count == '0;
    up       = !bus.load && bus.tick && bus.mode == MODE_UP;
    dn       = !bus.load && bus.tick && bus.mode == MODE_DOWN;
    n_carry  = up && at_max;
    n_borrow = dn && at_zero;
    n_count  = bus.load ? (bus.load_val > MAX ? MAX : bus.load_val)
             : bus.mode == MODE_CLEAR ? '0
             : up ? (at_max ? (SAT ? MAX : '0) : bus.count + 1'b1)
             : dn ? (at_zero ? (SAT ? '0 : MAX) : bus.count - 1'b1)
             : bus.count;
  end
  // count and limit pulses registered together so carry/borrow align with the new count
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      bus.count  <= '0;
      bus.carry  <= 1'b0;
      bus.borrow <= 1'b0;
    end else begin
      bus.count  <= n_count;
      bus.carry  <= n_carry;
      bus.borrow <= n_borrow;
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed vector table plus corner sequences for the up/down counter
module tb_updown_counter_param;
  import updown_pkg::*;
`ifdef UPDOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [3:0] WU = SAT ? 4'd9 : 4'd0;
  localparam logic [3:0] WD = SAT ? 4'd0 : 4'd9;
  typedef struct {
    logic [1:0] mode;
    logic       load;
    logic [3:0] lv;
    int         n;
    logic [3:0] c;
    logic       t;
    logic       ca;
    logic       b;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nvec = 0;
  int nfail = 0;
  vec_t v[$];
  updown_counter_param_if #(.WIDTH(4)) bus ();
  updown_counter_param #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(1), .MAX_COUNT(9)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick_step(input string name);
    int i;
    i = 0;
    while (!bus.tick && i < 20) begin
      step(1);
      i++;
    end
    if (!bus.tick) chk({name, "_tick_timeout"}, 32'(bus.tick), 32'd1);
    step(1);
  endtask
  initial begin
    int n;
    bus.mode = MODE_UP;
    bus.load = 1'b0;
    bus.load_val = 4'd0;
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  9, 4'd0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  1, 4'd1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0, 80, 4'd9, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  9, 4'd9, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  1, WU,   1'b0, 1'b1, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  1, WU,   1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd0, 1'b1, 4'd15, 1, 4'd9, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd0, 1'b0, 4'd0,  7, 4'd9, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b1, 4'd3,  1, 4'd3, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd2, 1'b0, 4'd0,  9, 4'd3, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd2, 1'b0, 4'd0,  1, 4'd2, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd2, 1'b0, 4'd0, 20, 4'd0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd2, 1'b0, 4'd0, 10, WD,   1'b0, 1'b0, 1'b1});
    v.push_back(vec_t'{2'd2, 1'b0, 4'd0,  1, WD,   1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd0, 1'b1, 4'd5,  1, 4'd5, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd3, 1'b0, 4'd0,  1, 4'd0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  6, 4'd0, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  1, 4'd1, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd1, 1'b0, 4'd0,  9, 4'd1, 1'b1, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd3, 1'b0, 4'd0,  1, 4'd0, 1'b0, 1'b0, 1'b0});
    v.push_back(vec_t'{2'd0, 1'b1, 4'd9,  1, 4'd9, 1'b0, 1'b0, 1'b0});
    #22;
    chk("reset_state", {bus.count, bus.tick, bus.carry, bus.borrow}, 7'b0);
    rst_n = 1'b1;
    foreach (v[i]) begin
      bus.mode = v[i].mode;
      bus.load = v[i].load;
      bus.load_val = v[i].lv;
      step(v[i].n);
      chk($sformatf("vec%0d", i), {bus.count, bus.tick, bus.carry, bus.borrow},
          {v[i].c, v[i].t, v[i].ca, v[i].b});
    end
    bus.load = 1'b0;
    bus.mode = MODE_UP;
    for (int k = 0; k < 3; k++) begin
      tick_step("up_limit");
      chk($sformatf("up_limit_count%0d", k), 32'(bus.count), SAT ? 32'd9 : 32'(k));
      chk($sformatf("up_limit_carry%0d", k), 32'(bus.carry), 32'(SAT || k == 0));
      step(1);
      chk($sformatf("up_limit_carry_drop%0d", k), 32'({bus.carry, bus.borrow}), 32'd0);
    end
    bus.load = 1'b1;
    bus.load_val = 4'd0;
    bus.mode = MODE_HOLD;
    step(1);
    chk("load_zero", 32'(bus.count), 32'd0);
    bus.load = 1'b0;
    bus.mode = MODE_DOWN;
    for (int k = 0; k < 3; k++) begin
      tick_step("dn_limit");
      chk($sformatf("dn_limit_count%0d", k), 32'(bus.count), SAT ? 32'd0 : 32'(9 - k));
      chk($sformatf("dn_limit_borrow%0d", k), 32'(bus.borrow), 32'(SAT || k == 0));
      step(1);
      chk($sformatf("dn_limit_borrow_drop%0d", k), 32'({bus.carry, bus.borrow}), 32'd0);
    end
    bus.mode = MODE_HOLD;
    bus.load = 1'b1;
    bus.load_val = 4'd7;
    step(1);
    bus.load = 1'b0;
    chk("load_seven", 32'(bus.count), 32'd7);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", {bus.count, bus.tick, bus.carry, bus.borrow}, 7'b0);
    #2 rst_n = 1'b1;
    bus.mode = MODE_UP;
    n = 0;
    while (!bus.tick && n < 20) begin
      step(1);
      n++;
    end
    chk("post_reset_tick_edges", 32'(n), 32'd9);
    step(1);
    chk("post_reset_count", 32'(bus.count), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
